// File: rtl/seq_regfile_wb.sv
// rtl/seq_regfile_wb.sv - SEQ decode/writeback stage: register file, CC, halt latch, retire counter
module seq_regfile_wb #(
   parameter int              WIDTH  = 64,
   parameter int              NREG   = 15,
   parameter logic [3:0]      RSP_ID = 4'd4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wb_en,
   input  logic [3:0]       icode,
   input  logic [3:0]       ifun,
   input  logic [3:0]       rA,
   input  logic [3:0]       rB,
   input  logic             cnd,
   input  logic [2:0]       cc_in,
   input  logic [WIDTH-1:0] valE,
   input  logic [WIDTH-1:0] valM,
   input  logic [3:0]       dbg_addr,
   output logic [3:0]       srcA,
   output logic [3:0]       srcB,
   output logic [3:0]       dstE,
   output logic [3:0]       dstM,
   output logic [WIDTH-1:0] valA,
   output logic [WIDTH-1:0] valB,
   output logic [2:0]       cc_out,
   output logic             halted,
   output logic [WIDTH-1:0] dbg_data,
   output logic [31:0]      retired
);

   localparam logic [3:0] RNONE   = 4'hF;
   localparam logic [3:0] NREG_ID = 4'(NREG);

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];
   logic [2:0]       cc_q, cc_d;
   logic             halted_q, halted_d;
   logic [31:0]      retired_q, retired_d;
   logic             commit;

   // ifun does not steer any selection in this stage
   logic unused_ifun;
   assign unused_ifun = ^ifun;

   // Register ID selection from the instruction code
   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      case (icode)
         I_RRMOVQ: begin
            srcA = rA;
            dstE = cnd ? rB : RNONE;
         end
         I_IRMOVQ: dstE = rB;
         I_RMMOVQ: begin
            srcA = rA;
            srcB = rB;
         end
         I_MRMOVQ: begin
            srcB = rB;
            dstM = rA;
         end
         I_OPQ: begin
            srcA = rA;
            srcB = rB;
            dstE = rB;
         end
         I_CALL: begin
            srcB = RSP_ID;
            dstE = RSP_ID;
         end
         I_RET: begin
            srcA = RSP_ID;
            srcB = RSP_ID;
            dstE = RSP_ID;
         end
         I_PUSHQ: begin
            srcA = rA;
            srcB = RSP_ID;
            dstE = RSP_ID;
         end
         I_POPQ: begin
            srcA = RSP_ID;
            srcB = RSP_ID;
            dstE = RSP_ID;
            dstM = rA;
         end
         default: ;
      endcase
   end

   // Asynchronous reads of committed state; IDs outside the file read as zero
   always_comb begin
      valA     = '0;
      valB     = '0;
      dbg_data = '0;
      if (srcA < NREG_ID) valA = regs_q[srcA];
      if (srcB < NREG_ID) valB = regs_q[srcB];
      if (dbg_addr < NREG_ID) dbg_data = regs_q[dbg_addr];
   end

   // Next architectural state; M port written after E so valM wins a collision
   always_comb begin
      regs_d    = regs_q;
      cc_d      = cc_q;
      halted_d  = halted_q;
      retired_d = retired_q;
      commit    = wb_en && !halted_q;
      if (commit) begin
         retired_d = retired_q + 32'd1;
         if (icode == I_HALT) begin
            halted_d = 1'b1;
         end else begin
            if (dstE < NREG_ID) regs_d[dstE] = valE;
            if (dstM < NREG_ID) regs_d[dstM] = valM;
            if (icode == I_OPQ) cc_d = cc_in;
         end
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         cc_q      <= 3'b100;
         halted_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         regs_q    <= regs_d;
         cc_q      <= cc_d;
         halted_q  <= halted_d;
         retired_q <= retired_d;
      end
   end

   assign cc_out  = cc_q;
   assign halted  = halted_q;
   assign retired = retired_q;

endmodule
